// File: rtl/vga_ram_port_arbiter.sv
// Shares the single RAM port B between the display fetch path, which always wins,
// and an auxiliary requester that only gets the free slots. Reads are tagged so the data returned on ram_q_b reaches the right requester.
module vga_ram_port_arbiter #(
   parameter int          ADDR_WIDTH    = 16,
   parameter int          RAM_LATENCY   = 1,
   parameter logic [15:0] STARVE_LIMIT  = 16'd800,
   parameter bit          BLANK_ONLY_WR = 1'b1
) (
   input  logic                  pix_clk,
   input  logic                  reset,
   input  logic                  bright,
   input  logic                  disp_req,
   input  logic [ADDR_WIDTH-1:0] disp_addr,
   output logic                  disp_rvalid,
   input  logic                  aux_req,
   input  logic                  aux_we,
   input  logic [ADDR_WIDTH-1:0] aux_addr,
   input  logic [15:0]           aux_wdata,
   output logic                  aux_gnt,
   output logic                  aux_rvalid,
   output logic                  aux_starve,
   output logic [ADDR_WIDTH-1:0] ram_addr_b,
   output logic                  ram_we_b,
   output logic [15:0]           ram_d_b,
   input  logic [15:0]           ram_q_b
);

   typedef enum logic [1:0] {SLOT_IDLE, SLOT_DISP, SLOT_AUX} slot_e;
   typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_AUXRD} tag_e;

   // Stage 0 lines up with ram_addr_b. The last stage lines up with the matching ram_q_b.
   localparam int TAG_STAGES = RAM_LATENCY + 1;

   slot_e                 slot;
   logic                  auxAllowed;
   tag_e                  tagIn;
   logic [ADDR_WIDTH-1:0] ramAddr_q, ramAddr_d;
   logic                  ramWe_q, ramWe_d;
   logic [15:0]           ramD_q, ramD_d;
   tag_e                  tag_q [TAG_STAGES];
   logic [15:0]           waitCnt_q, waitCnt_d;
   logic                  starve_q, starve_d;

   always_comb begin
      auxAllowed = !(BLANK_ONLY_WR && aux_we && bright);
      slot       = SLOT_IDLE;
      if (disp_req) begin
         slot = SLOT_DISP;
      end else if (aux_req && auxAllowed) begin
         slot = SLOT_AUX;
      end
   end

   assign aux_gnt = (slot == SLOT_AUX) && !reset;

   always_comb begin
      ramAddr_d = ramAddr_q;
      ramWe_d   = 1'b0;
      ramD_d    = ramD_q;
      tagIn     = TAG_NONE;
      case (slot)
         SLOT_DISP: begin
            ramAddr_d = disp_addr;
            tagIn     = TAG_DISP;
         end
         SLOT_AUX: begin
            ramAddr_d = aux_addr;
            ramWe_d   = aux_we;
            ramD_d    = aux_wdata;
            if (!aux_we) begin
               tagIn = TAG_AUXRD;
            end
         end
         default: begin
         end
      endcase
   end

   // The wait counter saturates rather than wrapping, so a starved requester never looks fresh again.
   always_comb begin
      waitCnt_d = waitCnt_q;
      starve_d  = starve_q;
      if (aux_gnt || !aux_req) begin
         waitCnt_d = 16'd0;
      end else if (waitCnt_q != 16'hFFFF) begin
         waitCnt_d = waitCnt_q + 16'd1;
      end
      if (aux_gnt) begin
         starve_d = 1'b0;
      end else if (aux_req && (waitCnt_d >= STARVE_LIMIT)) begin
         starve_d = 1'b1;
      end
   end

   always_ff @(posedge pix_clk) begin
      if (reset) begin
         ramAddr_q <= '0;
         ramWe_q   <= 1'b0;
         ramD_q    <= 16'd0;
         waitCnt_q <= 16'd0;
         starve_q  <= 1'b0;
         for (int i = 0; i < TAG_STAGES; i++) begin
            tag_q[i] <= TAG_NONE;
         end
      end else begin
         ramAddr_q <= ramAddr_d;
         ramWe_q   <= ramWe_d;
         ramD_q    <= ramD_d;
         waitCnt_q <= waitCnt_d;
         starve_q  <= starve_d;
         tag_q[0]  <= tagIn;
         for (int i = 1; i < TAG_STAGES; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   assign ram_addr_b  = ramAddr_q;
   assign ram_we_b    = ramWe_q;
   assign ram_d_b     = ramD_q;
   assign aux_starve  = starve_q;
   assign disp_rvalid = (tag_q[TAG_STAGES-1] == TAG_DISP);
   assign aux_rvalid  = (tag_q[TAG_STAGES-1] == TAG_AUXRD);

endmodule
